dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator for the MEM stage of the 5-stage RISC-V core. It drives the requester side of the data-memory BRAM port (ena/wea/addra/dina/douta).
- Accepts one load or store per request handshake and converts RV32I funct3 sizes into byte enables and replicated write data.
- Waits out the fixed BRAM read latency, then returns aligned, sign- or zero-extended load data.
- Misaligned and illegal accesses are flagged and never reach the BRAM.

Parameters:
- ADDR_BITS, 10: BRAM word-address width. Depth is 2^ADDR_BITS 32-bit words.
- READ_LAT, 1: BRAM cycles from an ena read cycle to valid douta. Legal values are 1 or 2.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  single-cycle response strobe.
- rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal request; valid only with rsp_valid.
- ena  out  1  BRAM enable.
- wea  out  4  BRAM byte write enables.
- addra  out  ADDR_BITS  BRAM word address.
- dina  out  32  BRAM write data.
- douta  in  32  BRAM read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; latency counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - ena=0, wea=0, addra=0, dina=0.
  - An in-flight read is discarded and no response is issued.
  - req_ready rises in the first clock cycle after deassertion.
- States: IDLE, RWAIT, RESP.
- req_ready = (state==IDLE). A request is accepted in cycle T when req_valid && req_ready.
- BRAM drive in the accept cycle only (combinational from the request, gated by the accept):
  - addra = req_addr[ADDR_BITS+1:2]. Upper address bits are ignored (the address wraps).
  - off = req_addr[1:0].
  - ena=0 and wea=0 in every cycle other than the accept cycle.
- Error check, done in the accept cycle:
  - Illegal: funct3 in {3,6,7}, or a store with funct3 in {4,5}.
  - Misaligned: H/HU with off[0]=1, or W with off!=0.
  - On error: ena=0, wea=0, next state is RESP with rsp_err=1 and rsp_rdata=0.
- Store (legal):
  - ena=1.
  - wea: SB = 4'b0001<<off; SH = 4'b0011<<off; SW = 4'b1111.
  - dina: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
  - Next state RESP, so rsp_valid=1 at T+1 with rsp_rdata=0 and rsp_err=0.
- Load (legal):
  - ena=1, wea=0.
  - Offset and funct3 are latched; next state RWAIT.
  - RWAIT counts READ_LAT cycles. In cycle T+READ_LAT, douta is sampled and formatted into rsp_rdata.
    - B/BU: byte douta[8*off+:8], sign- or zero-extended.
    - H/HU: douta[16*off[1]+:16], sign- or zero-extended.
    - W: douta unchanged.
  - Next state RESP, so rsp_valid=1 at T+READ_LAT+1.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_err are registered and stable during it.
  - Then IDLE.
  - rsp_rdata holds its value until the next response. rsp_err is cleared when RESP exits.
- Throughput:
  - Store or error: one request per 2 cycles.
  - Load: one request per READ_LAT+2 cycles.
- Requester obligation: request fields are sampled only in the accept cycle. Requests presented while req_ready=0 are ignored, and the requester must hold them.

Test Plan:
- SW addr=0x14, wdata=0xABCD1234 → at T: ena=1, wea=1111, addra=5, dina=0xABCD1234. At T+1: rsp_valid=1, rsp_err=0. A following LW of 0x14 returns 0xABCD1234 at T'+READ_LAT+1.
- SB addr=0x17, wdata=0x000000F0 → wea=1000, dina=0xF0F0F0F0. LB 0x17 returns 0xFFFFFFF0; LBU 0x17 returns 0x000000F0.
- SH addr=0x22, wdata=0x00008001 → wea=1100, dina=0x80018001. LH 0x22 returns 0xFFFF8001; LHU 0x22 returns 0x00008001.
- LW addr=0x13 and SH addr=0x11 → ena=0 and wea=0 throughout. rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0. Same response for funct3=3.
- Back-to-back loads with req_valid held high, READ_LAT=2 → req_ready=0 for 3 cycles after each accept, with accepts 4 cycles apart. Repeat with READ_LAT=1.
- Assert rst_n=0 during RWAIT of a load → rsp_valid never pulses for that load, all outputs go to 0 immediately, and the next load after reset returns correct data.

Source files
------------

// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator for the RV32I core: drives the BRAM requester port,
// checks size/alignment, and returns aligned, extended load data after the fixed read latency.
module dmem_lsu #(
    parameter int ADDR_BITS = 10,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 ena,
    output logic [3:0]           wea,
    output logic [ADDR_BITS-1:0] addra,
    output logic [31:0]          dina,
    input  logic [31:0]          douta
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RWAIT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] LAT_C = 2'(READ_LAT);

    state_t      state_q;
    logic        ready_q;
    logic [1:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [1:0]  off_s;
    logic        accept_s;
    logic        illegal_s;
    logic        misal_s;
    logic        err_s;
    logic [3:0]  wea_st_s;
    logic [31:0] dina_st_s;
    logic        unused_s;

    function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    fmt_load = {{24{b[7]}}, b};
            3'd1:    fmt_load = {{16{h[15]}}, h};
            3'd2:    fmt_load = d;
            3'd4:    fmt_load = {24'd0, b};
            3'd5:    fmt_load = {16'd0, h};
            default: fmt_load = 32'd0;
        endcase
    endfunction

    assign off_s     = req_addr[1:0];
    assign req_ready = ready_q && (state_q == S_IDLE);
    assign accept_s  = req_valid && req_ready;
    assign err_s     = illegal_s || misal_s;
    assign unused_s  = ^{req_addr[31:ADDR_BITS+2]};

    // Size decode: legality, alignment and store lane steering
    always_comb begin
        illegal_s = 1'b0;
        misal_s   = 1'b0;
        case (req_funct3)
            3'd0: misal_s = 1'b0;
            3'd1: misal_s = off_s[0];
            3'd2: misal_s = (off_s != 2'd0);
            3'd4: illegal_s = req_we;
            3'd5: begin
                illegal_s = req_we;
                misal_s   = off_s[0];
            end
            default: illegal_s = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'd0: begin
                wea_st_s  = 4'b0001 << off_s;
                dina_st_s = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wea_st_s  = 4'b0011 << off_s;
                dina_st_s = {2{req_wdata[15:0]}};
            end
            default: begin
                wea_st_s  = 4'b1111;
                dina_st_s = req_wdata;
            end
        endcase
    end

    // BRAM port is driven only in a legal accept cycle and held at zero otherwise
    always_comb begin
        if (accept_s && !err_s) begin
            ena   = 1'b1;
            addra = req_addr[ADDR_BITS+1:2];
            if (req_we) begin
                wea  = wea_st_s;
                dina = dina_st_s;
            end else begin
                wea  = 4'b0000;
                dina = 32'd0;
            end
        end else begin
            ena   = 1'b0;
            addra = '0;
            wea   = 4'b0000;
            dina  = 32'd0;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            cnt_q       <= 2'd0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        if (err_s || req_we) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_s;
                            rsp_rdata_q <= 32'd0;
                            state_q     <= S_RESP;
                        end else begin
                            off_q   <= off_s;
                            f3_q    <= req_funct3;
                            cnt_q   <= 2'd1;
                            state_q <= S_RWAIT;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RWAIT: begin
                    if (cnt_q == LAT_C) begin
                        rsp_rdata_q <= fmt_load(douta, f3_q, off_q);
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        cnt_q       <= 2'd0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    cnt_q       <= 2'd0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a READ_LAT=1 instance carries the vector table,
// a READ_LAT=2 instance joins the back-to-back throughput sequence.
module tb_dmem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        req_valid, req_we, req_ready, rsp_valid, rsp_err, ena;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_rdata, dina, douta;
    logic [3:0]  wea;
    logic [9:0]  addra;

    logic        r2_valid, r2_we, r2_ready, rsp2_valid, rsp2_err, ena2;
    logic [2:0]  r2_funct3;
    logic [31:0] r2_addr, r2_wdata, rsp2_rdata, dina2, douta2, rd2_q;
    logic [3:0]  wea2;
    logic [9:0]  addra2;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem2 [0:1023];

    dmem_lsu #(.ADDR_BITS(10), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    dmem_lsu #(.ADDR_BITS(10), .READ_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r2_valid), .req_ready(r2_ready), .req_we(r2_we),
        .req_funct3(r2_funct3), .req_addr(r2_addr), .req_wdata(r2_wdata),
        .rsp_valid(rsp2_valid), .rsp_rdata(rsp2_rdata), .rsp_err(rsp2_err),
        .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2)
    );

    // BRAM models: one-cycle and two-cycle read pipelines
    always @(posedge clk) begin
        if (ena) begin
            for (int i = 0; i < 4; i++)
                if (wea[i]) mem1[addra][8*i +: 8] <= dina[8*i +: 8];
            douta <= mem1[addra];
        end
    end

    always @(posedge clk) begin
        if (ena2) begin
            for (int k = 0; k < 4; k++)
                if (wea2[k]) mem2[addra2][8*k +: 8] <= dina2[8*k +: 8];
            rd2_q <= mem2[addra2];
        end
        douta2 <= rd2_q;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ena;
        logic [3:0]  wea;
        logic [9:0]  addra;
        logic [31:0] dina;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vt [20];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h, required %h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        logic got;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        #1;
        chk("ready", idx, 32'(req_ready), 32'd1);
        chk("ena",   idx, 32'(ena),   32'(v.ena));
        chk("wea",   idx, 32'(wea),   32'(v.wea));
        chk("addra", idx, 32'(addra), 32'(v.addra));
        chk("dina",  idx, dina, v.dina);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
        end
        chk("latency", idx, 32'(n), 32'(v.lat));
        chk("rdata",   idx, rsp_rdata, v.rdata);
        chk("err",     idx, 32'(rsp_err), 32'(v.err));
        @(negedge clk);
        chk("pulse_end", idx, 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rdata_hold", idx, rsp_rdata, v.rdata);
    endtask

    int acc1 [$];
    int acc2 [$];
    int seen;

    initial begin
        //          we    f3    addr          wdata         ena   wea      addra   dina          err   rdata         lat
        vt[0]  = '{1'b1, 3'd2, 32'h14,       32'hABCD1234, 1'b1, 4'b1111, 10'd5, 32'hABCD1234, 1'b0, 32'h0,        1};
        vt[1]  = '{1'b0, 3'd2, 32'h14,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'hABCD1234, 2};
        vt[2]  = '{1'b1, 3'd0, 32'h17,       32'h000000F0, 1'b1, 4'b1000, 10'd5, 32'hF0F0F0F0, 1'b0, 32'h0,        1};
        vt[3]  = '{1'b0, 3'd0, 32'h17,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'hFFFFFFF0, 2};
        vt[4]  = '{1'b0, 3'd4, 32'h17,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'h000000F0, 2};
        vt[5]  = '{1'b1, 3'd1, 32'h22,       32'h00008001, 1'b1, 4'b1100, 10'd8, 32'h80018001, 1'b0, 32'h0,        1};
        vt[6]  = '{1'b0, 3'd1, 32'h22,       32'h0,        1'b1, 4'b0000, 10'd8, 32'h0,        1'b0, 32'hFFFF8001, 2};
        vt[7]  = '{1'b0, 3'd5, 32'h22,       32'h0,        1'b1, 4'b0000, 10'd8, 32'h0,        1'b0, 32'h00008001, 2};
        vt[8]  = '{1'b0, 3'd2, 32'h13,       32'h0,        1'b0, 4'b0000, 10'd0, 32'h0,        1'b1, 32'h0,        1};
        vt[9]  = '{1'b1, 3'd1, 32'h11,       32'h0000FFFF, 1'b0, 4'b0000, 10'd0, 32'h0,        1'b1, 32'h0,        1};
        vt[10] = '{1'b0, 3'd3, 32'h14,       32'h0,        1'b0, 4'b0000, 10'd0, 32'h0,        1'b1, 32'h0,        1};
        vt[11] = '{1'b1, 3'd4, 32'h14,       32'h00000055, 1'b0, 4'b0000, 10'd0, 32'h0,        1'b1, 32'h0,        1};
        vt[12] = '{1'b0, 3'd0, 32'h14,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'h00000034, 2};
        vt[13] = '{1'b0, 3'd1, 32'h16,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'hFFFFF0CD, 2};
        vt[14] = '{1'b0, 3'd4, 32'h15,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'h00000012, 2};
        vt[15] = '{1'b1, 3'd2, 32'h00001014, 32'h11223344, 1'b1, 4'b1111, 10'd5, 32'h11223344, 1'b0, 32'h0,        1};
        vt[16] = '{1'b0, 3'd2, 32'h14,       32'h0,        1'b1, 4'b0000, 10'd5, 32'h0,        1'b0, 32'h11223344, 2};
        vt[17] = '{1'b1, 3'd1, 32'h20,       32'h1234BEEF, 1'b1, 4'b0011, 10'd8, 32'hBEEFBEEF, 1'b0, 32'h0,        1};
        vt[18] = '{1'b0, 3'd2, 32'h20,       32'h0,        1'b1, 4'b0000, 10'd8, 32'h0,        1'b0, 32'h8001BEEF, 2};
        vt[19] = '{1'b0, 3'd5, 32'h23,       32'h0,        1'b0, 4'b0000, 10'd0, 32'h0,        1'b1, 32'h0,        1};

        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        r2_valid  = 1'b0; r2_we  = 1'b0; r2_funct3  = 3'd0; r2_addr  = 32'd0; r2_wdata  = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 0, 32'({req_ready, rsp_valid, rsp_err, ena, wea}), 32'd0);
        chk("rst_bus",  0, rsp_rdata | dina | 32'(addra), 32'd0);
        rst_n = 1'b1;
        #1 chk("rst_ready_low", 0, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready_rise", 0, 32'(req_ready), 32'd1);

        for (int v = 0; v < 20; v++) run_vec(vt[v], v);

        // Back-to-back loads with valid held: LAT1 every 3 cycles, LAT2 every 4
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h14;
        r2_valid  = 1'b1; r2_we  = 1'b0; r2_funct3  = 3'd2; r2_addr  = 32'h14;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready) acc1.push_back(c);
            if (r2_ready)  acc2.push_back(c);
            if (rsp_valid) chk("b2b_rdata", c, rsp_rdata, 32'h11223344);
            if (rsp2_valid) chk("b2b_err2", c, 32'(rsp2_err), 32'd0);
        end
        req_valid = 1'b0;
        r2_valid  = 1'b0;
        chk("b2b_n1", 1, 32'(acc1.size()), 32'd5);
        chk("b2b_n2", 2, 32'(acc2.size()), 32'd4);
        for (int i = 1; i < acc1.size(); i++) chk("b2b_gap1", i, 32'(acc1[i] - acc1[i-1]), 32'd3);
        for (int i = 1; i < acc2.size(); i++) chk("b2b_gap2", i, 32'(acc2[i] - acc2[i-1]), 32'd4);
        repeat (6) @(negedge clk);

        // Reset asserted while a load waits on the BRAM
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 0, 32'({req_ready, rsp_valid, rsp_err, ena, wea}), 32'd0);
        chk("mid_rst_bus",  0, rsp_rdata | dina | 32'(addra), 32'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 0, 32'(seen), 32'd0);
        chk("mid_rst_ready", 0, 32'(req_ready), 32'd1);
        run_vec(vt[16], 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
